apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- APB requester (initiator) that drives the PCLK/PRESETn/PADDR/PSELx/PENABLE/PWRITE/PWDATA/PRDATA bus of the peripheral slaves in this design, including mod_top.
- Accepts single read/write commands on a valid/ready interface and sequences each one through the APB SETUP and ACCESS phases.
- Returns read data and an error flag on a one-cycle response strobe.
- Includes a PREADY watchdog, so a stalled slave cannot hang the requester.

Parameters:
- ADDR_W, default `addrWidth (32): width of PADDR and cmd_addr.
- DATA_W, default `dataWidth (32): width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- TIMEOUT, default 16: number of ACCESS cycles without PREADY before the transfer is aborted. Legal range 2..255.

Ports:
- PCLK  in  1  single clock; all logic on the rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted this cycle when cmd_valid is also high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errored transfers.
- rsp_err  out  1  PSLVERR was seen, or the watchdog timed out.
- PADDR  out  ADDR_W  APB address.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  slave ready; tie to 1 for slaves without wait states.
- PSLVERR  in  1  slave error; tie to 0 when the slave has none.

Behaviour:
- Reset: PRESETn low asynchronously forces the following. Any transfer in flight is dropped with no response.
  - state = IDLE.
  - All outputs 0: PADDR, PSELx, PENABLE, PWRITE, PWDATA, rsp_valid, rsp_rdata, rsp_err.
  - Watchdog counter = 0.
- States: IDLE, SETUP, ACCESS (2-bit encoding).
- cmd_ready is combinational: cmd_ready = (state==IDLE) | (state==ACCESS & PREADY).
- Accept = cmd_valid & cmd_ready. On accept at edge N:
  - PADDR, PWRITE and PWDATA are registered from cmd_*. PWDATA is loaded on reads as well.
  - state goes to SETUP.
- SETUP (cycle N+1): PSELx=1, PENABLE=0. Always exactly one cycle; then go to ACCESS.
- ACCESS: PSELx=1, PENABLE=1. Watchdog increments every ACCESS cycle with PREADY=0.
  - PREADY=1: transfer completes.
  - Next edge: rsp_valid=1 for one cycle; rsp_err=PSLVERR; rsp_rdata=PRDATA if read and not PSLVERR, else 0.
  - Then next state = SETUP if a new command is accepted in the same cycle (back-to-back, PSELx stays 1, PENABLE drops to 0); otherwise IDLE.
  - Watchdog clears.
  - Watchdog reaches TIMEOUT-1 with PREADY still 0: abort.
  - Next edge: PSELx=0, PENABLE=0, state = IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - cmd_ready stays 0 in the abort cycle.
- Zero-wait latency: accept at edge N → SETUP N+1 → ACCESS N+2 → rsp_valid high in cycle N+3.
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS. After a transfer they hold their last values; they are not zeroed.
- IDLE: PSELx=0, PENABLE=0.
- rsp_valid has no backpressure; the consumer must always sink it.
- Simultaneous events:
  - PREADY and timeout in the same cycle: PREADY wins, normal completion.
  - PSLVERR is sampled only when PREADY=1 in ACCESS.
- Watchdog width is 8 bits and it saturates; it never wraps.

Decomposition:
- Shared include macros.vh:
  - existing `addrWidth / `dataWidth;
  - new `APB_IDLE=2'd0, `APB_SETUP=2'd1, `APB_ACCESS=2'd2;
  - `APB_TIMEOUT_DEF=16.
- One sub-module, apb_wdog: 8-bit saturating counter.
  - Inputs: clr, inc, limit.
  - Output: expired.
  - Same PCLK/PRESETn.

Test Plan:
- Write, PREADY=1: cmd addr=0x80000000, wdata=1 at edge N.
  - Cycle N+1: PSELx=1, PENABLE=0, PADDR=0x80000000, PWRITE=1, PWDATA=1.
  - Cycle N+2: PENABLE=1.
  - Cycle N+3: rsp_valid=1, rsp_err=0, rsp_rdata=0; PSELx=0.
- Read, 3 wait states: PREADY=0 for 3 ACCESS cycles, then 1 with PRDATA=0x00000001.
  - rsp_rdata=0x1, rsp_err=0.
  - PADDR stable throughout; cmd_ready=0 until the completing cycle.
- Back-to-back: cmd_valid held high with writes to 0x80000000 then 0x80000004 (wdata 144).
  - PSELx never drops between the two transfers.
  - Exactly one PENABLE=0 SETUP cycle between them.
  - Two rsp_valid pulses.
- Slave error: read with PREADY=1, PSLVERR=1, PRDATA=0xDEAD.
  - rsp_err=1, rsp_rdata=0.
- Timeout: PREADY held 0, TIMEOUT=16.
  - After 16 ACCESS cycles: PSELx=0, rsp_valid=1, rsp_err=1, state IDLE.
  - Next command is accepted normally.
- Reset mid-ACCESS: PRESETn low for 80 ns during a wait-stated write.
  - PSELx, PENABLE and rsp_valid go to 0 immediately, with no clock edge needed.
  - No response is issued; the first command after reset completes normally.

Source files
------------

// File: rtl/apb_master_bridge_pkg.sv
// Shared widths, defaults and APB state encodings for the APB requester bridge.
package apb_master_bridge_pkg;

  localparam int ADDR_WIDTH      = 32;
  localparam int DATA_WIDTH      = 32;
  localparam int APB_TIMEOUT_DEF = 16;

  localparam logic [1:0] APB_IDLE   = 2'd0;
  localparam logic [1:0] APB_SETUP  = 2'd1;
  localparam logic [1:0] APB_ACCESS = 2'd2;

endpackage

// File: rtl/apb_master_bridge_wdog.sv
// 8-bit saturating wait-state counter; expired flags that the count has reached limit.
module apb_wdog (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= 8'd0;
    end else if (clr) begin
      r_cnt <= 8'd0;
    end else if (inc && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign expired = (r_cnt >= limit);

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: sequences valid/ready commands through SETUP/ACCESS and returns a response strobe.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDR_W  = ADDR_WIDTH,
  parameter int DATA_W  = DATA_WIDTH,
  parameter int TIMEOUT = APB_TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              w_in_access;
  logic              w_accept;
  logic              w_done;
  logic              w_abort;
  logic              w_expired;
  logic              w_wdog_clr;
  logic              w_wdog_inc;

  assign w_in_access = (r_state == APB_ACCESS);
  assign cmd_ready   = (r_state == APB_IDLE) | (w_in_access & PREADY);
  assign w_accept    = cmd_valid & cmd_ready;
  assign w_done      = w_in_access & PREADY;
  // PREADY has priority over the watchdog in the same cycle.
  assign w_abort     = w_in_access & ~PREADY & w_expired;

  assign w_wdog_clr  = ~w_in_access | PREADY | w_abort;
  assign w_wdog_inc  = w_in_access & ~PREADY;

  apb_wdog u_wdog (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clr     (w_wdog_clr),
    .inc     (w_wdog_inc),
    .limit   (8'(TIMEOUT - 1)),
    .expired (w_expired)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      APB_IDLE:   if (w_accept) w_state_next = APB_SETUP;
      APB_SETUP:  w_state_next = APB_ACCESS;
      APB_ACCESS: begin
        if (w_done)       w_state_next = w_accept ? APB_SETUP : APB_IDLE;
        else if (w_abort) w_state_next = APB_IDLE;
      end
      default:    w_state_next = APB_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= APB_IDLE;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_paddr  <= cmd_addr;
        r_pwrite <= cmd_write;
        r_pwdata <= cmd_wdata;
      end
      r_rsp_valid <= w_done | w_abort;
      r_rsp_err   <= w_done ? PSLVERR : w_abort;
      // Read data only survives a clean read completion.
      r_rsp_rdata <= (w_done && !r_pwrite && !PSLVERR) ? PRDATA : '0;
    end
  end

  assign PSELx     = (r_state != APB_IDLE);
  assign PENABLE   = w_in_access;
  assign PADDR     = r_paddr;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule
